sign_extender_4_to_16: RTL and testbench
========================================

SIGN_EXTENDER_4_TO_16 -- requirements
Module: sign_extender_4_to_16

Interface
REQ-001 Parameter IN_W, default 4: input field width; only 4 is supported.
REQ-002 Parameter OUT_W, default 16: output word width; only 16 is supported.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in  input  4  immediate field to extend, bit 3 is the sign bit.
REQ-007 mode  input  2  extension mode selector.
REQ-008 in_valid  input  1  qualifies in/mode for capture this cycle.
REQ-009 out  output  16  registered extended word.
REQ-010 out_valid  output  1  high for the cycle(s) out holds a newly captured result.
REQ-011 out_neg  output  1  registered copy of the sign bit of out (out[15]).

Function
REQ-012 The extension SHALL be computed combinationally from in/mode and captured into out on the rising clk edge when in_valid=1; latency is exactly 1 cycle.
REQ-013 mode 00 (sign-extend): out[3:0]=in, out[15:4]=12 copies of in[3].
REQ-014 mode 01 (zero-extend): out[3:0]=in, out[15:4]=0.
REQ-015 mode 10 (sign-extend, shift left 1): out = (sign-extended in) << 1, with out[0]=0 and out[15:5] copies of in[3].
REQ-016 mode 11 (sign-extend, shift left 4): out[3:0]=0, out[7:4]=in, out[15:8] copies of in[3].
REQ-017 All arithmetic SHALL be two's complement; no overflow is possible and no saturation applies.
REQ-018 When in_valid=0, out and out_neg SHALL hold their previous values and out_valid SHALL be 0 on the following cycle.
REQ-019 out_valid SHALL equal in_valid delayed by one cycle; back-to-back valid inputs yield back-to-back valid outputs, one per cycle, with no stalls.
REQ-020 out_neg SHALL always equal out[15] as registered, and is 0 for every mode-01 result.
REQ-021 in and mode are sampled only when in_valid=1; X on in/mode while in_valid=0 SHALL NOT affect outputs.
REQ-022 The design SHALL contain no state other than the out, out_neg and out_valid registers.

Reset
REQ-023 While rst_n=0, out SHALL be 16'h0000, out_neg 0 and out_valid 0, asynchronously and regardless of clk.
REQ-024 A capture in progress when rst_n asserts SHALL be discarded; the first valid result after reset appears one cycle after the first clk edge with rst_n=1 and in_valid=1.

Verification
REQ-025 mode=00, in=4'b0101, in_valid=1 -> next cycle out=16'h0005, out_neg=0, out_valid=1.
REQ-026 mode=00, in=4'b1010 -> out=16'hFFFA, out_neg=1; mode=01, in=4'b1010 -> out=16'h000A, out_neg=0.
REQ-027 mode=10, in=4'b1000 -> out=16'hFFF0; mode=10, in=4'b0111 -> out=16'h000E.
REQ-028 mode=11, in=4'b0111 -> out=16'h0070; mode=11, in=4'b1000 -> out=16'hFF80.
REQ-029 Valid result 16'hFFFA followed by in_valid=0 for 3 cycles with random in -> out holds 16'hFFFA, out_valid=0 for those cycles.
REQ-030 Assert rst_n=0 mid-stream between clock edges -> out=16'h0000, out_valid=0 immediately; after release, exhaustive sweep of all 16 in values x 4 modes matches REQ-013..REQ-016.

Source files
------------

// File: rtl/sign_extender_4_to_16.sv
// Registered immediate-field extender: widens a 4-bit field to 16 bits using one
// of four extension modes, with a one-cycle valid-qualified pipeline stage.
module sign_extender_4_to_16 #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             out_neg
);

  typedef enum logic [1:0] {
    MODE_SEXT      = 2'b00,
    MODE_ZEXT      = 2'b01,
    MODE_SEXT_SHL1 = 2'b10,
    MODE_SEXT_SHL4 = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic             sign;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] ext;

  assign mode_sel = mode_e'(mode);
  assign sign     = in[IN_W-1];
  assign sext     = {{(OUT_W-IN_W){sign}}, in};
  assign zext     = {{(OUT_W-IN_W){1'b0}}, in};

  // Shifted modes reuse the sign-extended word, so the vacated high bits stay
  // sign copies and the vacated low bits fill with zero.
  always_comb begin
    // NOTE: default first so every path assigns ext and no latch is inferred.
    ext = sext;
    case (mode_sel)
      MODE_SEXT:      ext = sext;
      MODE_ZEXT:      ext = zext;
      MODE_SEXT_SHL1: ext = {sext[OUT_W-2:0], 1'b0};
      MODE_SEXT_SHL4: ext = {sext[OUT_W-5:0], 4'b0000};
      default:        ext = sext;
    endcase
  end

  // in/mode are only looked at when in_valid is high; otherwise out holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_neg   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      out_valid <= in_valid;
      if (in_valid) begin
        out     <= ext;
        out_neg <= ext[OUT_W-1];
      end
    end
  end

endmodule

// File: tb/tb_sign_extender_4_to_16.sv
// Scoreboard bench for sign_extender_4_to_16: the driver queues expected words,
// an independent monitor pops and compares whenever out_valid is seen.
module tb_sign_extender_4_to_16;

  typedef struct packed {
    logic [15:0] word;
    logic        neg;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in;
  logic [1:0]  mode;
  logic        in_valid;
  logic [15:0] out;
  logic        out_valid;
  logic        out_neg;

  int          checks;
  int          failures;
  exp_t        sb[$];
  logic [15:0] last_out;
  logic        last_neg;

  sign_extender_4_to_16 #(.IN_W(4), .OUT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .mode      (mode),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .out_neg   (out_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  // Arithmetic reference: interpret the field as a signed integer and scale it.
  function automatic exp_t model(input logic [3:0] v, input logic [1:0] m);
    int   s;
    int   r;
    exp_t e;
    s = v[3] ? int'(v) - 16 : int'(v);
    case (m)
      2'd0:    r = s;
      2'd1:    r = int'(v);
      2'd2:    r = s * 2;
      default: r = s * 16;
    endcase
    e.word = r[15:0];
    e.neg  = r[15];
    return e;
  endfunction

  task automatic send(input logic [3:0] v, input logic [1:0] m, input logic [15:0] word);
    exp_t e;
    @(negedge clk);
    in       = v;
    mode     = m;
    in_valid = 1'b1;
    e.word   = word;
    e.neg    = word[15];
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in       = 4'($urandom);
      mode     = 2'($urandom);
    end
  endtask

  // Monitor: samples on the falling edge, well away from the capture edge.
  initial begin
    exp_t e;
    last_out = 16'h0000;
    last_neg = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_valid", 32'(out_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            check("out", 32'(out), 32'(e.word));
            check("out_neg", 32'(out_neg), 32'(e.neg));
            last_out = e.word;
            last_neg = e.neg;
          end
        end else begin
          check("hold_out", 32'(out), 32'(last_out));
          check("hold_neg", 32'(out_neg), 32'(last_neg));
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in       = 4'h0;
    mode     = 2'b00;
    in_valid = 1'b0;
    #3;
    check("reset_out", 32'(out), 32'h0000);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_neg", 32'(out_neg), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results, issued back to back.
    send(4'b0101, 2'b00, 16'h0005);
    send(4'b1010, 2'b00, 16'hFFFA);
    send(4'b1010, 2'b01, 16'h000A);
    send(4'b1000, 2'b10, 16'hFFF0);
    send(4'b0111, 2'b10, 16'h000E);
    send(4'b0111, 2'b11, 16'h0070);
    send(4'b1000, 2'b11, 16'hFF80);
    send(4'b1111, 2'b01, 16'h000F);
    send(4'b1111, 2'b00, 16'hFFFF);
    send(4'b0000, 2'b11, 16'h0000);
    send(4'b1010, 2'b00, 16'hFFFA);
    idle(3);

    // Valid capture still in flight when reset asserts between edges.
    send(4'b1001, 2'b00, 16'hFFF9);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out", 32'(out), 32'h0000);
    check("midreset_valid", 32'(out_valid), 32'd0);
    check("midreset_neg", 32'(out_neg), 32'd0);
    sb.delete();
    last_out = 16'h0000;
    last_neg = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Exhaustive sweep against the arithmetic model, back to back.
    for (int m = 0; m < 4; m++) begin
      for (int v = 0; v < 16; v++) begin
        exp_t e;
        e = model(4'(v), 2'(m));
        send(4'(v), 2'(m), e.word);
      end
    end
    idle(2);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
